board_mark_reg: RTL and testbench

BOARD_MARK_REG -- requirements
Module: board_mark_reg

---
 rtl/board_pkg.sv | 13 +
 rtl/btn_edge_sync.sv | 37 +++
 rtl/board_mark_reg.sv | 187 ++++++++++++++++++
 tb/tb_board_mark_reg.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared types for the board mark register: commit FSM states and player encoding.
package board_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for a raw push button.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw asynchronous button level
//   sync       : synchronised button level (registered)
//   rise_c     : one-cycle rising edge of sync (combinational)
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic sync,
  output logic rise_c
);

  logic       meta;
  logic [1:0] fill;
  logic       prev;

  // fill tracks when sync carries real samples; until then prev is held high
  // so a button held across reset release never reads as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      fill <= 2'b00;
      prev <= 1'b1;
    end else begin
      meta <= btn;
      sync <= meta;
      fill <= {fill[0], 1'b1};
      prev <= fill[1] ? sync : 1'b1;
    end
  end

  assign rise_c = fill[1] & sync & ~prev;

endmodule

// File: rtl/board_mark_reg.sv
// Board mark register: commits debounced button presses as alternating player
// marks on a CELLS-cell board, with accept/reject pulses and occupancy count.
// Optional one-level undo is compiled in when BOARD_MARK_UNDO_EN is defined.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   pos_i        : selected cell index
//   btn_i        : raw commit button
//   clear_i      : synchronous board clear
//   undo_i       : raw undo button (BOARD_MARK_UNDO_EN only)
//   cell_mark_o  : per-cell occupied flags
//   cell_owner_o : per-cell owner (0 = player A, 1 = player B)
//   player_o     : player to move
//   accept_o     : one-cycle pulse, move (or undo) stored
//   reject_o     : one-cycle pulse, move (or undo) refused
//   full_o       : all cells occupied (combinational)
//   move_cnt_o   : number of occupied cells
module board_mark_reg
  import board_pkg::*;
#(
  parameter int unsigned CELLS = 9,
  parameter int unsigned POS_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [POS_W-1:0]             pos_i,
  input  logic                         btn_i,
  input  logic                         clear_i,
`ifdef BOARD_MARK_UNDO_EN
  input  logic                         undo_i,
`endif
  output logic [CELLS-1:0]             cell_mark_o,
  output logic [CELLS-1:0]             cell_owner_o,
  output logic                         player_o,
  output logic                         accept_o,
  output logic                         reject_o,
  output logic                         full_o,
  output logic [$clog2(CELLS+1)-1:0]   move_cnt_o
);

  localparam int unsigned CNT_W = $clog2(CELLS+1);

  state_t             state, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [CELLS-1:0]   mark_d, owner_d, sel;
  logic [CNT_W-1:0]   cnt_d;
  logic               player_d, accept_d, reject_d;
  logic               btn_sync, btn_rise, pos_ok, hit;

  btn_edge_sync u_btn_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn_i),
    .sync   (btn_sync),
    .rise_c (btn_rise)
  );

`ifdef BOARD_MARK_UNDO_EN
  logic               undo_rise;
  logic [POS_W-1:0]   last_pos, last_pos_d;
  logic               last_vld, last_vld_d;
  logic [CELLS-1:0]   usel;

  btn_edge_sync u_undo_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (undo_i),
    .sync   (),
    .rise_c (undo_rise)
  );

  assign usel = CELLS'(1) << last_pos;
`endif

  // Out-of-range positions shift the one-hot select to zero.
  assign sel    = CELLS'(1) << pos_q;
  assign pos_ok = (32'(pos_q) < CELLS);
  assign hit    = |(cell_mark_o & sel);
  assign full_o = (move_cnt_o == CNT_W'(CELLS));

  // Next-state and datapath update.
  always_comb begin
    state_d  = state;
    pos_d    = pos_q;
    mark_d   = cell_mark_o;
    owner_d  = cell_owner_o;
    player_d = player_o;
    cnt_d    = move_cnt_o;
    accept_d = 1'b0;
    reject_d = 1'b0;
`ifdef BOARD_MARK_UNDO_EN
    last_pos_d = last_pos;
    last_vld_d = last_vld;
`endif

    case (state)
      IDLE: begin
        if (btn_rise) begin
          pos_d   = pos_i;
          state_d = COMMIT;
        end
`ifdef BOARD_MARK_UNDO_EN
        else if (undo_rise) begin
          if (last_vld) begin
            mark_d     = cell_mark_o & ~usel;
            owner_d    = cell_owner_o & ~usel;
            cnt_d      = move_cnt_o - CNT_W'(1);
            player_d   = ~player_o;
            accept_d   = 1'b1;
            last_vld_d = 1'b0;
          end else begin
            reject_d = 1'b1;
          end
        end
`endif
        else if (btn_sync) begin
          state_d = HOLD;
        end
      end
      COMMIT: begin
        state_d = HOLD;
        if (pos_ok && !hit && !full_o) begin
          mark_d   = cell_mark_o | sel;
          owner_d  = (player_o == PLAYER_B) ? (cell_owner_o | sel) : cell_owner_o;
          cnt_d    = move_cnt_o + CNT_W'(1);
          player_d = ~player_o;
          accept_d = 1'b1;
`ifdef BOARD_MARK_UNDO_EN
          last_pos_d = pos_q;
          last_vld_d = 1'b1;
`endif
        end else begin
          reject_d = 1'b1;
        end
      end
      HOLD: begin
        if (!btn_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides everything, including a commit in flight.
    if (clear_i) begin
      mark_d   = '0;
      owner_d  = '0;
      cnt_d    = '0;
      player_d = PLAYER_A;
      accept_d = 1'b0;
      reject_d = 1'b0;
      state_d  = btn_sync ? HOLD : IDLE;
`ifdef BOARD_MARK_UNDO_EN
      last_vld_d = 1'b0;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pos_q        <= '0;
      cell_mark_o  <= '0;
      cell_owner_o <= '0;
      move_cnt_o   <= '0;
      player_o     <= PLAYER_A;
      accept_o     <= 1'b0;
      reject_o     <= 1'b0;
`ifdef BOARD_MARK_UNDO_EN
      last_pos     <= '0;
      last_vld     <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      pos_q        <= pos_d;
      cell_mark_o  <= mark_d;
      cell_owner_o <= owner_d;
      move_cnt_o   <= cnt_d;
      player_o     <= player_d;
      accept_o     <= accept_d;
      reject_o     <= reject_d;
`ifdef BOARD_MARK_UNDO_EN
      last_pos     <= last_pos_d;
      last_vld     <= last_vld_d;
`endif
    end
  end

endmodule

// File: tb/tb_board_mark_reg.sv
// Directed self-checking bench for board_mark_reg (undo checks only when
// BOARD_MARK_UNDO_EN is defined).
module tb_board_mark_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pos_i;
  logic       btn_i;
  logic       clear_i;
  logic       undo_i;
  logic [8:0] cell_mark_o;
  logic [8:0] cell_owner_o;
  logic       player_o;
  logic       accept_o;
  logic       reject_o;
  logic       full_o;
  logic [3:0] move_cnt_o;

  int total = 0;
  int passed = 0;
  int fails = 0;
  int n_acc, n_rej, cyc = 0, start, first_pulse;

  board_mark_reg #(.CELLS(9), .POS_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pos_i        (pos_i),
    .btn_i        (btn_i),
    .clear_i      (clear_i),
`ifdef BOARD_MARK_UNDO_EN
    .undo_i       (undo_i),
`endif
    .cell_mark_o  (cell_mark_o),
    .cell_owner_o (cell_owner_o),
    .player_o     (player_o),
    .accept_o     (accept_o),
    .reject_o     (reject_o),
    .full_o       (full_o),
    .move_cnt_o   (move_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the rising edge and tally pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (accept_o) n_acc++;
    if (reject_o) n_rej++;
    if ((accept_o || reject_o) && first_pulse < 0) first_pulse = cyc - start;
  endtask

  task automatic clr_counts();
    n_acc = 0;
    n_rej = 0;
    first_pulse = -1;
    start = cyc;
  endtask

  task automatic press(input logic [3:0] p);
    clr_counts();
    pos_i = p;
    btn_i = 1'b1;
    repeat (6) tick();
    btn_i = 1'b0;
    repeat (6) tick();
  endtask

  task automatic undo_press();
    clr_counts();
    undo_i = 1'b1;
    repeat (6) tick();
    undo_i = 1'b0;
    repeat (6) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0; pos_i = 4'd0; btn_i = 1'b0; clear_i = 1'b0; undo_i = 1'b0;
    clr_counts();
    #2;
    chk("rst_mark",   32'(cell_mark_o),  32'h0);
    chk("rst_owner",  32'(cell_owner_o), 32'h0);
    chk("rst_player", 32'(player_o),     32'h0);
    chk("rst_cnt",    32'(move_cnt_o),   32'h0);
    chk("rst_full",   32'(full_o),       32'h0);
    chk("rst_pulses", 32'({accept_o, reject_o}), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // First move on cell 4.
    press(4'd4);
    chk("m1_acc",     32'(n_acc), 32'd1);
    chk("m1_rej",     32'(n_rej), 32'd0);
    chk("m1_latency", 32'(first_pulse), 32'd4);
    chk("m1_mark",    32'(cell_mark_o),  32'h010);
    chk("m1_owner",   32'(cell_owner_o), 32'h000);
    chk("m1_player",  32'(player_o),     32'h1);
    chk("m1_cnt",     32'(move_cnt_o),   32'd1);

    // Same cell again is refused.
    press(4'd4);
    chk("dup_rej",    32'(n_rej), 32'd1);
    chk("dup_acc",    32'(n_acc), 32'd0);
    chk("dup_mark",   32'(cell_mark_o), 32'h010);
    chk("dup_player", 32'(player_o),    32'h1);
    chk("dup_cnt",    32'(move_cnt_o),  32'd1);

    // Out-of-range positions.
    press(4'd9);
    chk("p9_rej",  32'(n_rej), 32'd1);
    chk("p9_acc",  32'(n_acc), 32'd0);
    press(4'd15);
    chk("p15_rej", 32'(n_rej), 32'd1);
    chk("p15_mark", 32'(cell_mark_o), 32'h010);

    // Held 50 cycles while pos sweeps; pos 2 is the value in the edge cycle.
    clr_counts();
    pos_i = 4'd0;
    btn_i = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      pos_i = 4'(k % 9);
    end
    btn_i = 1'b0;
    repeat (6) tick();
    chk("hold_acc",   32'(n_acc), 32'd1);
    chk("hold_rej",   32'(n_rej), 32'd0);
    chk("hold_mark",  32'(cell_mark_o),  32'h014);
    chk("hold_owner", 32'(cell_owner_o), 32'h004);
    chk("hold_cnt",   32'(move_cnt_o),   32'd2);

    // Clear.
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    tick();
    chk("clr1_mark",   32'(cell_mark_o),  32'h0);
    chk("clr1_player", 32'(player_o),     32'h0);
    chk("clr1_cnt",    32'(move_cnt_o),   32'd0);

    // Fill the board in order; owners alternate A,B,A,...
    begin
      int tot_acc;
      tot_acc = 0;
      for (int c = 0; c < 9; c++) begin
        press(4'(c));
        tot_acc += n_acc;
      end
      chk("fill_acc", 32'(tot_acc), 32'd9);
    end
    chk("fill_mark",  32'(cell_mark_o),  32'h1FF);
    chk("fill_owner", 32'(cell_owner_o), 32'h0AA);
    chk("fill_full",  32'(full_o),       32'h1);
    chk("fill_cnt",   32'(move_cnt_o),   32'd9);
    press(4'd0);
    chk("full_rej",   32'(n_rej), 32'd1);
    chk("full_acc",   32'(n_acc), 32'd0);
    chk("full_cnt",   32'(move_cnt_o), 32'd9);

    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    tick();
    chk("clr2_mark",   32'(cell_mark_o),  32'h0);
    chk("clr2_owner",  32'(cell_owner_o), 32'h0);
    chk("clr2_player", 32'(player_o),     32'h0);
    chk("clr2_full",   32'(full_o),       32'h0);

    // Button held across reset release must not commit.
    btn_i = 1'b1;
    pos_i = 4'd3;
    rst_n = 1'b0;
    clr_counts();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("held_rst_pulses", 32'(n_acc + n_rej), 32'd0);
    chk("held_rst_cnt",    32'(move_cnt_o),    32'd0);
    btn_i = 1'b0;
    repeat (6) tick();
    press(4'd3);
    chk("after_held_acc",  32'(n_acc), 32'd1);
    chk("after_held_mark", 32'(cell_mark_o), 32'h008);

    // Reset asserted while in COMMIT: no pulse, everything zero.
    clr_counts();
    pos_i = 4'd5;
    btn_i = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    btn_i = 1'b0;
    #1;
    chk("abort_mark", 32'(cell_mark_o), 32'h0);
    chk("abort_cnt",  32'(move_cnt_o),  32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("abort_pulses", 32'(n_acc + n_rej), 32'd0);
    chk("abort_player", 32'(player_o), 32'h0);

`ifdef BOARD_MARK_UNDO_EN
    do_reset();
    press(4'd2);
    chk("u_move_acc",  32'(n_acc), 32'd1);
    chk("u_move_mark", 32'(cell_mark_o), 32'h004);
    undo_press();
    chk("u1_acc",    32'(n_acc), 32'd1);
    chk("u1_mark",   32'(cell_mark_o), 32'h0);
    chk("u1_cnt",    32'(move_cnt_o),  32'd0);
    chk("u1_player", 32'(player_o),    32'h0);
    undo_press();
    chk("u2_rej",    32'(n_rej), 32'd1);
    chk("u2_acc",    32'(n_acc), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
